// File: rtl/width_conv_pkg.sv
// rtl/width_conv_pkg.sv - shared helpers for the narrow/wide width converters
//
// Purpose:
//   Lane-index arithmetic and counter sizing shared by narrow2wide and its
//   wide-to-narrow counterpart. Both sides must agree on beat-to-lane order.
//
// Contents:
//   cnt_w(ratio)                    width of a beat counter covering 0..ratio-1
//   lane_of(beat, ratio, msb_first) lane a given beat number occupies in the
//                                   wide word

package width_conv_pkg;

  // Width of a beat counter; never returns 0 so the counter is always a real
  // vector even for degenerate ratios.
  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Beat k lands in the top lane first when msb_first is set, otherwise it
  // lands in lane k counting up from the LSBs.
  function automatic int lane_of(input int beat, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/n2w_out_reg.sv
// rtl/n2w_out_reg.sv - single-entry output holding register for narrow2wide
//
// Purpose:
//   Holds one completed wide word (data, keep, last) until the downstream
//   consumer takes it. A load always wins and is only issued by the parent
//   when the entry is empty or draining in the same cycle, so no word is lost.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture load_* into the entry and mark it valid
//   load_data      word to capture
//   load_keep      per-lane keep flags to capture
//   load_last      word-closed-by-last flag to capture
//   drain          downstream ready; empties a valid entry when not reloaded
//   out_data       held word
//   out_keep       held keep flags
//   out_last       held last flag
//   out_valid      entry occupied

module n2w_out_reg #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  input  logic              drain,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_valid && drain) begin
      // Payload is left in place; only the valid flag matters once drained.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/narrow2wide.sv
// rtl/narrow2wide.sv - packs RATIO narrow beats into one wide word
//
// Purpose:
//   Receive-side width converter. Beats are accumulated lane by lane; a word
//   completes after RATIO beats or early on a beat carrying in_last. Completed
//   words go to a one-entry output register; if that entry is busy the word
//   parks in the accumulator (pend) and the input stalls until it drains.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      narrow beat
//   in_valid     beat present
//   in_last      beat closes the current word early
//   in_ready     converter can accept a beat (registered, = !pend)
//   out_data     packed word, lane i at [i*NARROW_W +: NARROW_W]
//   out_keep     bit i set when lane i holds received data
//   out_last     word was closed by in_last
//   out_valid    word present
//   out_ready    downstream accepts the word

module narrow2wide
  import width_conv_pkg::*;
#(
  parameter int NARROW_W  = 4,
  parameter int RATIO     = 2,
  parameter int WIDE_W    = NARROW_W * RATIO,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NARROW_W-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [WIDE_W-1:0]   out_data,
  output logic [RATIO-1:0]    out_keep,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int            CW        = cnt_w(RATIO);
  localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

  logic [CW-1:0]     cnt;
  logic [WIDE_W-1:0] acc;
  logic [RATIO-1:0]  acc_keep;
  logic              pend;
  logic              pend_last;

  logic [WIDE_W-1:0] merged;
  logic [RATIO-1:0]  merged_keep;
  logic              beat_ok;
  logic              word_done;
  logic              out_room;
  logic              pend_drain;
  logic              load;
  logic [WIDE_W-1:0] load_data;
  logic [RATIO-1:0]  load_keep;
  logic              load_last;

  // Accumulator with the current beat dropped into its lane.
  always_comb begin
    merged      = acc;
    merged_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_of(int'(cnt), RATIO, MSB_FIRST) == i) begin
        merged[i*NARROW_W +: NARROW_W] = in_data;
        merged_keep[i]                 = 1'b1;
      end
    end
  end

  // While a word is parked the accumulator is occupied, so no beat may enter.
  assign in_ready  = !pend;
  assign beat_ok   = in_valid && !pend;
  assign word_done = beat_ok && ((cnt == LAST_BEAT) || in_last);

  // Output entry can take a word this cycle if empty or being emptied now.
  assign out_room   = !out_valid || out_ready;
  assign pend_drain = pend && out_valid && out_ready;

  // A parked word has priority; no new word can complete while pend is set.
  assign load      = pend_drain || (word_done && out_room);
  assign load_data = pend ? acc       : merged;
  assign load_keep = pend ? acc_keep  : merged_keep;
  assign load_last = pend ? pend_last : in_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      acc_keep  <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else if (beat_ok) begin
      if (word_done) begin
        cnt <= '0;
        if (out_room) begin
          acc      <= '0;
          acc_keep <= '0;
        end else begin
          // Park the completed word in place until the output entry frees.
          acc       <= merged;
          acc_keep  <= merged_keep;
          pend      <= 1'b1;
          pend_last <= in_last;
        end
      end else begin
        cnt      <= cnt + CW'(1);
        acc      <= merged;
        acc_keep <= merged_keep;
      end
    end else if (pend_drain) begin
      acc       <= '0;
      acc_keep  <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end
  end

  n2w_out_reg #(
    .DATA_W (WIDE_W),
    .KEEP_W (RATIO)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .drain     (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_narrow2wide.sv
// tb/tb_narrow2wide.sv - scoreboard bench for narrow2wide

module tb_narrow2wide;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_keep;
  logic        a_out_last;
  logic        a_out_valid;

  logic        b_in_ready;
  logic [15:0] b_out_data;
  logic [3:0]  b_out_keep;
  logic        b_out_last;
  logic        b_out_valid;

  int tests = 0;
  int fails = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] ma_data = '0;
  logic [15:0] mb_data = '0;
  logic [3:0]  ma_keep = '0;
  logic [3:0]  mb_keep = '0;
  int          ma_k = 0;
  int          mb_k = 0;

  narrow2wide #(.NARROW_W(4), .RATIO(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_keep(a_out_keep), .out_last(a_out_last),
    .out_valid(a_out_valid), .out_ready(out_ready)
  );

  narrow2wide #(.NARROW_W(4), .RATIO(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Models: expected words are pushed as beats are accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      ma_k = 0; ma_data = '0; ma_keep = '0; qa.delete();
    end else if (in_valid && a_in_ready) begin
      ma_data[(1 - ma_k)*4 +: 4] = in_data;
      ma_keep[1 - ma_k] = 1'b1;
      if (ma_k == 1 || in_last) begin
        qa.push_back(32'({ma_data[7:0], ma_keep[1:0], in_last}));
        ma_k = 0; ma_data = '0; ma_keep = '0;
      end else begin
        ma_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mb_k = 0; mb_data = '0; mb_keep = '0; qb.delete();
    end else if (in_valid && b_in_ready) begin
      mb_data[mb_k*4 +: 4] = in_data;
      mb_keep[mb_k] = 1'b1;
      if (mb_k == 3 || in_last) begin
        qb.push_back(32'({mb_data, mb_keep, in_last}));
        mb_k = 0; mb_data = '0; mb_keep = '0;
      end else begin
        mb_k++;
      end
    end
  end

  // Monitors: compare every word the DUTs hand downstream.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_word: got 0x%0h, expected no word", {a_out_data, a_out_keep, a_out_last});
      end else begin
        chk("a_word", 32'({a_out_data, a_out_keep, a_out_last}), qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_word: got 0x%0h, expected no word", {b_out_data, b_out_keep, b_out_last});
      end else begin
        chk("b_word", 32'({b_out_data, b_out_keep, b_out_last}), qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until dut_a accepts it.
  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_last = l;
    while (!a_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int cyc;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data",  32'(a_out_data),  32'h0);
    chk("rst_out_keep",  32'(a_out_keep),  32'h0);
    chk("rst_out_last",  32'(a_out_last),  32'h0);
    chk("rst_in_ready",  32'(a_in_ready),  32'h1);
    chk("rst_b_valid",   32'(b_out_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic packing, 1-cycle latency, valid for exactly one cycle
    out_ready = 1'b1;
    send(4'hA, 1'b0);
    chk("basic_no_early_valid", 32'(a_out_valid), 32'h0);
    send(4'h5, 1'b0);
    chk("basic_valid", 32'(a_out_valid), 32'h1);
    chk("basic_data",  32'(a_out_data),  32'hA5);
    chk("basic_keep",  32'(a_out_keep),  32'h3);
    chk("basic_last",  32'(a_out_last),  32'h0);
    tick();
    chk("basic_one_cycle", 32'(a_out_valid), 32'h0);

    // Backpressure
    out_ready = 1'b0;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk("bp_in_ready_low", 32'(a_in_ready), 32'h0);
    chk("bp_hold_data",    32'(a_out_data), 32'h12);
    repeat (3) tick();
    chk("bp_hold_data_later", 32'(a_out_data), 32'h12);
    chk("bp_hold_valid",      32'(a_out_valid), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_registered", 32'(a_in_ready), 32'h0);
    tick();
    chk("bp_second_data",  32'(a_out_data),  32'h34);
    chk("bp_second_valid", 32'(a_out_valid), 32'h1);
    chk("bp_in_ready_back", 32'(a_in_ready), 32'h1);
    tick();
    chk("bp_drained", 32'(a_out_valid), 32'h0);

    // Early termination
    send(4'h7, 1'b1);
    chk("early_data", 32'(a_out_data), 32'h70);
    chk("early_keep", 32'(a_out_keep), 32'h2);
    chk("early_last", 32'(a_out_last), 32'h1);
    send(4'h8, 1'b0);
    send(4'h9, 1'b0);
    chk("after_early_data", 32'(a_out_data), 32'h89);
    chk("after_early_keep", 32'(a_out_keep), 32'h3);
    chk("after_early_last", 32'(a_out_last), 32'h0);

    // Reset mid-word
    send(4'hC, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",    32'(a_out_valid), 32'h0);
    chk("midrst_in_ready", 32'(a_in_ready),  32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk("midrst_data", 32'(a_out_data), 32'h34);
    chk("midrst_keep", 32'(a_out_keep), 32'h3);

    // Lane order on the LSB-first, 4-lane instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk("lsb4_valid", 32'(b_out_valid), 32'h1);
    chk("lsb4_data",  32'(b_out_data),  32'h4321);
    chk("lsb4_keep",  32'(b_out_keep),  32'hF);
    chk("lsb4_last",  32'(b_out_last),  32'h0);
    send(4'hA, 1'b0);
    send(4'h5, 1'b1);
    chk("lsb_early_data", 32'(b_out_data), 32'h005A);
    chk("lsb_early_keep", 32'(b_out_keep), 32'h3);
    chk("lsb_early_last", 32'(b_out_last), 32'h1);
    chk("msb_last_data",  32'(a_out_data), 32'hA5);
    chk("msb_last_last",  32'(a_out_last), 32'h1);

    // Random stress against the models
    beats = 0;
    cyc = 0;
    while (beats < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 4'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && a_in_ready) beats++;
      tick();
      cyc++;
    end
    chk("stress_beats", 32'(beats), 32'd10000);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("stress_a_drained", 32'(qa.size()), 32'h0);
    chk("stress_b_drained", 32'(qb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
